// File: rtl/mem_resp_pkg.sv
// mem_resp_pkg: shared types and helpers for the handshaking data-memory responder.
//   state_t          : responder FSM states (IDLE, BUSY).
//   WORD_OFFSET_BITS : number of byte-offset bits below the word index.
//   word_index()     : extracts the word index addr[addrWidth+1:2] from a byte address.
package mem_resp_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    localparam int unsigned WORD_OFFSET_BITS = 2;

    // The caller casts the result down to its own index width. Bits above
    // addrWidth+1 are masked off, which is what makes addresses alias.
    function automatic logic [31:0] word_index(input logic [31:0] addr,
                                               input int unsigned addrWidth);
        logic [31:0] mask;
        mask = (32'd1 << addrWidth) - 32'd1;
        return (addr >> WORD_OFFSET_BITS) & mask;
    endfunction

endpackage

// File: rtl/mem_word_array.sv
// mem_word_array: 2^ADDR_WIDTH x DATA_WIDTH word storage, no reset.
//   clk_i    : clock, rising edge
//   wrEn_i   : synchronous write enable
//   rdEn_i   : read enable; rdData_o updates on the same edge and holds otherwise
//   addr_i   : word index shared by the read and write ports
//   wrData_i : write data
//   rdData_o : registered read data
module mem_word_array #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 8
) (
    input  logic                  clk_i,
    input  logic                  wrEn_i,
    input  logic                  rdEn_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [DATA_WIDTH-1:0] wrData_i,
    output logic [DATA_WIDTH-1:0] rdData_o
);

    localparam int unsigned Depth = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [Depth];

    always_ff @(posedge clk_i) begin
        if (wrEn_i) begin
            mem[addr_i] <= wrData_i;
        end
        if (rdEn_i) begin
            rdData_o <= mem[addr_i];
        end
    end

endmodule

// File: rtl/data_mem_responder.sv
// data_mem_responder: memory end of the CPU load/store handshake. Accepts one
// read or write per Req_in/Ready_out handshake, waits WAIT_CYCLES edges, then
// completes the access with a one-cycle Valid_out pulse.
//   CLK_in     : clock, rising edge
//   Reset_n    : asynchronous active-low reset (aborts any access in flight)
//   Req_in     : request strobe, accepted when Req_in && Ready_out at an edge
//   Write_en   : 1 = write, 0 = read (sampled at accept)
//   Address_in : byte address (sampled at accept); bits above ADDR_WIDTH+1 ignored
//   Data_in    : write data (sampled at accept)
//   Ready_out  : responder idle
//   Valid_out  : one-cycle completion pulse
//   Data_out   : read data; holds between reads
//   Error_out  : misaligned-access flag, pulses with Valid_out
// Build option: define MISALIGN_CHECK_EN to flag accesses with Address_in[1:0] != 0
// (write suppressed, Data_out cleared, Error_out raised). Otherwise the low address
// bits are ignored and Error_out is tied to 0.
module data_mem_responder
    import mem_resp_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned ADDR_WIDTH  = 8,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic                  CLK_in,
    input  logic                  Reset_n,
    input  logic                  Req_in,
    input  logic                  Write_en,
    input  logic [31:0]           Address_in,
    input  logic [DATA_WIDTH-1:0] Data_in,
    output logic                  Ready_out,
    output logic                  Valid_out,
    output logic [DATA_WIDTH-1:0] Data_out,
    output logic                  Error_out
);

    localparam int unsigned CntW = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;

    state_t                stateQ;
    logic [CntW-1:0]       cntQ;
    logic                  isWriteQ;
    logic [ADDR_WIDTH-1:0] idxQ;
    logic [DATA_WIDTH-1:0] wrDataQ;
    logic                  readyQ;
    logic                  validQ;
    // Data_out shows the array read register only after a successful read;
    // otherwise (reset, misaligned completion) it shows zero.
    logic                  outSelQ;

    logic                  complete;
    logic                  misaligned;
    logic                  arrWrEn;
    logic                  arrRdEn;
    logic [DATA_WIDTH-1:0] arrRdData;

`ifdef MISALIGN_CHECK_EN
    logic errBitQ;
    logic errQ;
    assign misaligned = errBitQ;
    assign Error_out  = errQ;
`else
    assign misaligned = 1'b0;
    assign Error_out  = 1'b0;
`endif

    assign complete = (stateQ == BUSY) && (cntQ == '0);
    assign arrWrEn  = complete && isWriteQ && !misaligned;
    assign arrRdEn  = complete && !isWriteQ && !misaligned;

    always_ff @(posedge CLK_in or negedge Reset_n) begin
        if (!Reset_n) begin
            stateQ   <= IDLE;
            cntQ     <= '0;
            isWriteQ <= 1'b0;
            idxQ     <= '0;
            wrDataQ  <= '0;
            readyQ   <= 1'b1;
            validQ   <= 1'b0;
            outSelQ  <= 1'b0;
`ifdef MISALIGN_CHECK_EN
            errBitQ  <= 1'b0;
            errQ     <= 1'b0;
`endif
        end else begin
            validQ <= 1'b0;
`ifdef MISALIGN_CHECK_EN
            errQ   <= 1'b0;
`endif
            unique case (stateQ)
                IDLE: begin
                    if (Req_in) begin
                        isWriteQ <= Write_en;
                        idxQ     <= ADDR_WIDTH'(word_index(Address_in, ADDR_WIDTH));
                        wrDataQ  <= Data_in;
                        cntQ     <= CntW'(WAIT_CYCLES);
                        readyQ   <= 1'b0;
                        stateQ   <= BUSY;
`ifdef MISALIGN_CHECK_EN
                        errBitQ  <= (Address_in[WORD_OFFSET_BITS-1:0] != '0);
`endif
                    end
                end
                BUSY: begin
                    if (cntQ != '0) begin
                        cntQ <= cntQ - CntW'(1);
                    end else begin
                        // The array performs the access on this same edge.
                        validQ <= 1'b1;
                        readyQ <= 1'b1;
                        stateQ <= IDLE;
                        if (misaligned) begin
                            outSelQ <= 1'b0;
                        end else if (!isWriteQ) begin
                            outSelQ <= 1'b1;
                        end
`ifdef MISALIGN_CHECK_EN
                        errQ <= errBitQ;
`endif
                    end
                end
                default: begin
                    stateQ <= IDLE;
                    readyQ <= 1'b1;
                end
            endcase
        end
    end

    mem_word_array #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) uArray (
        .clk_i    (CLK_in),
        .wrEn_i   (arrWrEn),
        .rdEn_i   (arrRdEn),
        .addr_i   (idxQ),
        .wrData_i (wrDataQ),
        .rdData_o (arrRdData)
    );

    assign Ready_out = readyQ;
    assign Valid_out = validQ;
    assign Data_out  = outSelQ ? arrRdData : '0;

endmodule

// File: tb/tb_data_mem_responder.sv
module tb_data_mem_responder;

`ifdef MISALIGN_CHECK_EN
    localparam bit MisEn = 1'b1;
`else
    localparam bit MisEn = 1'b0;
`endif
    localparam int ExpLat = 3;  // WAIT_CYCLES + 1 with default parameters

    logic        CLK_in = 1'b0;
    logic        Reset_n = 1'b0;
    logic        Req_in = 1'b0;
    logic        Write_en = 1'b0;
    logic [31:0] Address_in = '0;
    logic [31:0] Data_in = '0;
    logic        Ready_out;
    logic        Valid_out;
    logic [31:0] Data_out;
    logic        Error_out;

    int tests = 0;
    int fails = 0;

    data_mem_responder dut (
        .CLK_in     (CLK_in),
        .Reset_n    (Reset_n),
        .Req_in     (Req_in),
        .Write_en   (Write_en),
        .Address_in (Address_in),
        .Data_in    (Data_in),
        .Ready_out  (Ready_out),
        .Valid_out  (Valid_out),
        .Data_out   (Data_out),
        .Error_out  (Error_out)
    );

    always #5 CLK_in = ~CLK_in;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] expData;
        logic        expErr;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic scramble();
        Write_en   = 1'($urandom);
        Address_in = $urandom;
        Data_in    = $urandom;
    endtask

    // Called 1 time unit after an edge with the responder idle. Accept occurs
    // on the next edge; returns latency in edges from accept to the Valid_out edge.
    task automatic txn(input logic we, input logic [31:0] addr, input logic [31:0] data,
                       input string tag, output logic [31:0] rd, output logic err,
                       output int lat);
        check({tag, " ready_before"}, 32'(Ready_out), 32'd1);
        Req_in     = 1'b1;
        Write_en   = we;
        Address_in = addr;
        Data_in    = data;
        @(posedge CLK_in);
        #1;
        Req_in = 1'b0;
        scramble();
        check({tag, " ready_busy"}, 32'(Ready_out), 32'd0);
        lat = -1;
        for (int n = 1; n <= 20; n++) begin
            @(posedge CLK_in);
            #1;
            if (Valid_out) begin
                lat = n;
                break;
            end
        end
        rd  = Data_out;
        err = Error_out;
    endtask

    function automatic int idxOf(input logic [31:0] a);
        return int'((a % 1024) / 4);
    endfunction

    vec_t        vecs[$];
    logic [31:0] modelMem[64];
    logic [31:0] modelOut;
    logic [31:0] rd;
    logic        err;
    int          lat;
    int          nValid;
    int          firstV;
    logic [31:0] firstData;

    initial begin
        // Reset
        repeat (2) @(posedge CLK_in);
        @(negedge CLK_in);
        Reset_n = 1'b1;
        @(posedge CLK_in);
        #1;
        check("reset ready", 32'(Ready_out), 32'd1);
        check("reset valid", 32'(Valid_out), 32'd0);
        check("reset data", Data_out, 32'd0);
        check("reset error", 32'(Error_out), 32'd0);

        // Directed table: rows chain back-to-back (request raised in the Valid cycle).
        vecs.push_back('{1'b1, 32'h0000_0010, 32'hDEADBEEF, 32'h0, 1'b0});
        vecs.push_back('{1'b0, 32'h0000_0010, 32'h0, 32'hDEADBEEF, 1'b0});
        vecs.push_back('{1'b1, 32'h0000_0404, 32'hCAFEF00D, 32'hDEADBEEF, 1'b0});
        vecs.push_back('{1'b0, 32'h0000_0004, 32'h0, 32'hCAFEF00D, 1'b0});
        vecs.push_back('{1'b0, 32'hFFFF_FC10, 32'h0, 32'hDEADBEEF, 1'b0});
        vecs.push_back('{1'b1, 32'h0000_0020, 32'h5A5A0000, 32'hDEADBEEF, 1'b0});
        vecs.push_back('{1'b1, 32'h0000_0022, 32'h11111111,
                         MisEn ? 32'h0 : 32'hDEADBEEF, MisEn});
        vecs.push_back('{1'b0, 32'h0000_0020, 32'h0,
                         MisEn ? 32'h5A5A0000 : 32'h11111111, 1'b0});
        vecs.push_back('{1'b0, 32'h0000_0011, 32'h0,
                         MisEn ? 32'h0 : 32'hDEADBEEF, MisEn});
        vecs.push_back('{1'b1, 32'h0000_000C, 32'h0BADCAFE,
                         MisEn ? 32'h0 : 32'hDEADBEEF, 1'b0});
        foreach (vecs[i]) begin
            txn(vecs[i].we, vecs[i].addr, vecs[i].data, $sformatf("vec%0d", i), rd, err, lat);
            check($sformatf("vec%0d latency", i), 32'(lat), 32'(ExpLat));
            check($sformatf("vec%0d data", i), rd, vecs[i].expData);
            check($sformatf("vec%0d error", i), 32'(err), 32'(vecs[i].expErr));
        end

        // Request pulsed while busy serving a read of 0x0C must be ignored.
        Req_in = 1'b1; Write_en = 1'b0; Address_in = 32'h0C;
        @(posedge CLK_in);
        #1;
        Req_in = 1'b1; Write_en = 1'b1; Address_in = 32'h0C; Data_in = 32'h12345678;
        nValid = 0;
        firstV = -1;
        firstData = '0;
        for (int n = 1; n <= 7; n++) begin
            @(posedge CLK_in);
            #1;
            Req_in = 1'b0;
            if (n == 1) check("busy ready low", 32'(Ready_out), 32'd0);
            if (n == 3) check("busy ready back", 32'(Ready_out), 32'd1);
            if (Valid_out) begin
                nValid++;
                if (firstV < 0) begin
                    firstV = n;
                    firstData = Data_out;
                end
            end
        end
        check("busy valid count", 32'(nValid), 32'd1);
        check("busy valid latency", 32'(firstV), 32'(ExpLat));
        check("busy read data", firstData, 32'h0BADCAFE);
        txn(1'b0, 32'h0C, 32'h0, "reread", rd, err, lat);
        check("reread data", rd, 32'h0BADCAFE);

        // Reset in the middle of a write: aborted, memory untouched.
        Req_in = 1'b1; Write_en = 1'b1; Address_in = 32'h20; Data_in = 32'hAAAA5555;
        @(posedge CLK_in);
        #1;
        Req_in = 1'b0;
        #2;
        Reset_n = 1'b0;
        #1;
        check("abort ready", 32'(Ready_out), 32'd1);
        check("abort valid", 32'(Valid_out), 32'd0);
        check("abort data", Data_out, 32'd0);
        check("abort error", 32'(Error_out), 32'd0);
        @(posedge CLK_in);
        @(negedge CLK_in);
        Reset_n = 1'b1;
        nValid = 0;
        for (int n = 0; n < 5; n++) begin
            @(posedge CLK_in);
            #1;
            if (Valid_out) nValid++;
        end
        check("abort no valid", 32'(nValid), 32'd0);
        modelOut = MisEn ? 32'h5A5A0000 : 32'h11111111;
        txn(1'b0, 32'h20, 32'h0, "post reset", rd, err, lat);
        check("post reset data", rd, modelOut);

        // Randomized traffic against a word-array model over 64 words.
        for (int i = 0; i < 64; i++) begin
            modelMem[i] = $urandom;
            txn(1'b1, 32'(i * 4), modelMem[i], "prefill", rd, err, lat);
        end
        check("prefill data", rd, modelOut);
        for (int t = 0; t < 150; t++) begin
            logic        we;
            logic [31:0] addr;
            logic [31:0] data;
            logic        mis;
            repeat ($urandom_range(0, 2)) begin
                @(posedge CLK_in);
                #1;
            end
            we   = 1'($urandom);
            data = $urandom;
            addr = ($urandom & 32'hFFFF_FC00) | 32'($urandom_range(0, 63) * 4);
            if ($urandom_range(0, 3) == 0) addr = addr | 32'($urandom_range(1, 3));
            mis = MisEn && (addr % 4 != 0);
            if (mis) begin
                modelOut = '0;
            end else if (we) begin
                modelMem[idxOf(addr)] = data;
            end else begin
                modelOut = modelMem[idxOf(addr)];
            end
            txn(we, addr, data, $sformatf("rnd%0d", t), rd, err, lat);
            check($sformatf("rnd%0d latency", t), 32'(lat), 32'(ExpLat));
            check($sformatf("rnd%0d data", t), rd, modelOut);
            check($sformatf("rnd%0d error", t), 32'(err), 32'(mis));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
- Multi-cycle data-memory responder: the memory end of the CPU load/store interface.
- Accepts one read or write request per handshake and inserts a fixed number of wait states.
- Completes the access and returns read data with a one-cycle valid pulse.
- Replaces the zero-latency data memory when the CPU runs with a handshaking memory stage.

Parameters:
- DATA_WIDTH, 32, word width in bits.
- ADDR_WIDTH, 8, word-index bits; depth = 2^ADDR_WIDTH words.
- WAIT_CYCLES, 2, wait states inserted before the access completes (0 allowed).

Ports:
- CLK_in  input  1  clock; all state changes on the rising edge.
- Reset_n  input  1  asynchronous active-low reset.
- Req_in  input  1  request strobe from the CPU.
- Write_en  input  1  1 = write, 0 = read; sampled only at accept.
- Address_in  input  32  byte address; sampled only at accept.
- Data_in  input  DATA_WIDTH  write data; sampled only at accept.
- Ready_out  output  1  responder idle; request accepted when Req_in && Ready_out at an edge.
- Valid_out  output  1  one-cycle completion pulse for reads and writes.
- Data_out  output  DATA_WIDTH  read data, registered; holds its value between reads.
- Error_out  output  1  misaligned-access flag; pulses together with Valid_out.

Behaviour:
- Reset (Reset_n low, asynchronous):
  - state=IDLE, counter=0, Ready_out=1, Valid_out=0, Data_out=0, Error_out=0.
  - Memory contents are not reset.
  - A transaction in flight is aborted; its pending write is discarded.
- FSM states: IDLE, BUSY.
- IDLE:
  - Ready_out=1.
  - On an edge with Req_in=1: capture Write_en, Address_in[ADDR_WIDTH+1:2] and Data_in; load counter=WAIT_CYCLES; go to BUSY.
- BUSY:
  - Ready_out=0.
  - Each edge with counter!=0: counter decrements.
  - Edge with counter==0, write request: mem[idx] <= captured data; Data_out unchanged.
  - Edge with counter==0, read request: Data_out <= mem[idx].
  - On that same edge: Valid_out <= 1, state <= IDLE.
- Latency: accept at edge k gives Valid_out high for exactly one cycle after edge k+WAIT_CYCLES+1.
  - WAIT_CYCLES=0: Valid_out follows the very next edge.
- Back-to-back: Ready_out is already 1 in the Valid_out cycle, so a request there is accepted with no bubble.
- Req_in while BUSY is ignored; there is no queueing. The initiator must hold Req_in until accepted.
- Addressing:
  - Address bits above ADDR_WIDTH+1 are ignored, so addresses alias and wrap modulo 2^(ADDR_WIDTH+2) bytes.
  - Address_in[1:0] is handled as described under Optional Feature.
- A read of a location written in an earlier completed transaction returns the new value; there is no read-during-write hazard because only one access is outstanding.
- Valid_out is never asserted without a preceding accept.

Optional Feature:
- Macro: MISALIGN_CHECK_EN.
- Defined:
  - Address_in[1:0]!=0 is captured as an error bit. Latency is unchanged.
  - At completion: write suppressed (memory unchanged), Data_out <= 0, Error_out=1 for the Valid_out cycle.
  - Error_out=0 for aligned accesses.
- Undefined:
  - Address_in[1:0] is ignored and the access proceeds on the truncated word index.
  - Error_out is tied to 0.

Decomposition:
- Package mem_resp_pkg holds:
  - state enum {IDLE, BUSY};
  - WORD_OFFSET_BITS=2;
  - helper function word_index(addr) returning addr[ADDR_WIDTH+1:2].
- Sub-module mem_word_array:
  - 2^ADDR_WIDTH x DATA_WIDTH storage;
  - synchronous write enable and a registered read port;
  - no reset.
- The FSM and wait counter stay in data_mem_responder.

Test Plan (defaults DATA_WIDTH=32, ADDR_WIDTH=8, WAIT_CYCLES=2):
1. Write 0x00000010 <- 0xDEADBEEF, then read 0x00000010.
   - Each Valid_out pulse lands exactly 3 edges after its accept.
   - Read returns Data_out=0xDEADBEEF.
2. Issue a new read request in the Valid_out cycle of a prior write.
   - Accepted immediately; second Valid_out follows 3 edges later; Ready_out is low only during BUSY.
3. Pulse Req_in (write 0x0C <- 0x12345678) while BUSY serving a read of 0x0C.
   - Request ignored; a later read of 0x0C returns the old value; exactly one Valid_out pulse.
4. Write 0x00000404 <- 0xCAFEF00D, then read 0x00000004.
   - Aliasing returns 0xCAFEF00D.
5. Drive Reset_n low during BUSY of a write 0x20 <- 0xAAAA5555.
   - Outputs take reset values immediately; no Valid_out pulse; a read of 0x20 after reset returns the pre-reset contents.
6. Write 0x00000022 <- 0x11111111.
   - With MISALIGN_CHECK_EN: Error_out=1 with Valid_out and word 0x20 unchanged.
   - Without it: Error_out=0 and word 0x20=0x11111111.
